// File: rtl/bitrev_pingpong_ctrl.sv
// Ping-pong bank sequencer between FFT stages: natural-order writes, bit-reversed reads,
// per-bank occupancy scoreboard, producer backpressure and a valid/ready output stream.
module bitrev_pingpong_ctrl #(
    parameter int K = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic         wr_en_o,
    output logic [K:0]   wr_addr_o,
    output logic         rd_en_o,
    output logic [K:0]   rd_addr_o,
    output logic         out_valid_o,
    output logic         out_last_o,
    input  logic         out_ready_i,
    output logic [1:0]   occupancy_o,
    output logic         frame_err_o
);

    localparam logic [K-1:0] CNT_MAX = {K{1'b1}};
    localparam logic [K-1:0] CNT_ONE = K'(1'b1);

    function automatic logic [K-1:0] bitrev(input logic [K-1:0] v);
        logic [K-1:0] r;
        r = {K{1'b0}};
        for (int i = 0; i < K; i++) begin
            r[i] = v[K-1-i];
        end
        return r;
    endfunction

    logic [K-1:0] wr_cnt_r;
    logic [K-1:0] rd_cnt_r;
    logic         wr_bank_r;
    logic         rd_bank_r;
    logic [1:0]   full_r;
    logic         out_valid_r;
    logic         out_last_r;
    logic         frame_err_r;

    logic         in_ready_s;
    logic         wr_en_s;
    logic         wr_last_s;
    logic         advance_s;
    logic         rd_en_s;
    logic         rd_last_s;
    logic [1:0]   full_nxt_s;

    // Handshake strobes and next scoreboard value
    always_comb begin
        in_ready_s = ~full_r[wr_bank_r];
        wr_en_s    = in_valid_i & in_ready_s;
        wr_last_s  = (wr_cnt_r == CNT_MAX);
        // A read may only be issued when the output register is free or being consumed
        advance_s  = ~out_valid_r | out_ready_i;
        rd_en_s    = full_r[rd_bank_r] & advance_s;
        rd_last_s  = (rd_cnt_r == CNT_MAX);

        full_nxt_s = full_r;
        if (wr_en_s && wr_last_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
        end
        // Writer and reader never share a bank in transit, so set and clear never collide
        if (rd_en_s && rd_last_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
        end
    end

    // Write-side counter, bank pointer and sticky framing check
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_r    <= {K{1'b0}};
            wr_bank_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (wr_en_s) begin
            wr_cnt_r <= wr_cnt_r + CNT_ONE;
            if (wr_last_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            if (in_last_i != wr_last_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

    // Read-side counter and bank pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_r  <= {K{1'b0}};
            rd_bank_r <= 1'b0;
        end else if (rd_en_s) begin
            rd_cnt_r <= rd_cnt_r + CNT_ONE;
            if (rd_last_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
        end
    end

    // Bank occupancy scoreboard
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
        end
    end

    // Output valid/last track the SRAM's one-cycle read latency; held while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= rd_en_s;
            out_last_r  <= rd_en_s & rd_last_s;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign wr_en_o     = wr_en_s;
    assign wr_addr_o   = {wr_bank_r, wr_cnt_r};
    assign rd_en_o     = rd_en_s;
    assign rd_addr_o   = {rd_bank_r, bitrev(rd_cnt_r)};
    assign out_valid_o = out_valid_r;
    assign out_last_o  = out_last_r;
    assign occupancy_o = {1'b0, full_r[0]} + {1'b0, full_r[1]};
    assign frame_err_o = frame_err_r;

endmodule

// File: tb/tb_bitrev_pingpong_ctrl.sv
// Bench for bitrev_pingpong_ctrl (K=3): frame-level reference model with an emulated SRAM,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bitrev_pingpong_ctrl;
    localparam int K = 3;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_i, in_valid_i, in_last_i, in_ready_o, wr_en_o, rd_en_o;
    logic [K:0] wr_addr_o, rd_addr_o;
    logic out_valid_o, out_last_o, out_ready_i, frame_err_o;
    logic [1:0] occupancy_o;

    always #5 clk = ~clk;

    bitrev_pingpong_ctrl #(.K(K)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i),
        .in_ready_o(in_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .out_valid_o(out_valid_o),
        .out_last_o(out_last_o), .out_ready_i(out_ready_i),
        .occupancy_o(occupancy_o), .frame_err_o(frame_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pcnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int brev(input int x);
        int r = 0;
        int v = x;
        for (int i = 0; i < K; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Reference model: counts since reset; everything else follows by arithmetic
    int  m_in, m_rd, m_out_idx;
    bit  m_ov, m_err, known;
    int  mem [0:2*N-1];
    int  rdata;
    int  fc;
    bit  e_ready, e_wen, adv, e_ren;
    int  wr_log[$], rd_log[$], ov_log[$], last_log[$];

    always @(negedge clk) begin
        if (known) begin
            fc      = m_in / N - m_rd / N;
            e_ready = (fc < 2);
            e_wen   = in_valid_i && e_ready;
            adv     = !m_ov || out_ready_i;
            e_ren   = (fc > 0) && adv;
            chk("in_ready",  int'(in_ready_o),  int'(e_ready));
            chk("wr_en",     int'(wr_en_o),     int'(e_wen));
            chk("wr_addr",   int'(wr_addr_o),   ((m_in / N) % 2) * N + m_in % N);
            chk("rd_en",     int'(rd_en_o),     int'(e_ren));
            chk("rd_addr",   int'(rd_addr_o),   ((m_rd / N) % 2) * N + brev(m_rd % N));
            chk("occupancy", int'(occupancy_o), fc);
            chk("out_valid", int'(out_valid_o), int'(m_ov));
            chk("frame_err", int'(frame_err_o), int'(m_err));
            if (m_ov) begin
                chk("out_last", int'(out_last_o), int'(m_out_idx % N == N - 1));
                chk("out_data", rdata, (m_out_idx / N) * N + brev(m_out_idx % N));
            end
        end
        if (wr_en_o === 1'b1) wr_log.push_back(int'(wr_addr_o));
        if (rd_en_o === 1'b1) rd_log.push_back(int'(rd_addr_o));
        ov_log.push_back(int'(out_valid_o === 1'b1));
        if (out_valid_o === 1'b1 && out_ready_i === 1'b1) last_log.push_back(int'(out_last_o));
        if (wr_en_o === 1'b1) mem[wr_addr_o] = m_in;
        if (rd_en_o === 1'b1) rdata = mem[rd_addr_o];
        if (rst_i) begin
            m_in = 0; m_rd = 0; m_out_idx = 0; m_ov = 0; m_err = 0; known = 1;
        end else if (known) begin
            if (e_wen) begin
                if (in_last_i != (m_in % N == N - 1)) m_err = 1;
                m_in++;
            end
            if (adv) begin
                m_ov = e_ren;
                if (e_ren) m_out_idx = m_rd;
            end
            if (e_ren) m_rd++;
        end
    end

    task automatic step(input bit v, input bit r, input bit bad);
        in_valid_i  = v;
        out_ready_i = r;
        in_last_i   = v && (((pcnt % N) == N - 1) != bad);
        #1;
        if (v && in_ready_o === 1'b1) pcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); ov_log.delete(); last_log.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready_o),  1);
        chk({tag, "_occupancy"}, int'(occupancy_o), 0);
        chk({tag, "_out_valid"}, int'(out_valid_o), 0);
        chk({tag, "_out_last"},  int'(out_last_o),  0);
        chk({tag, "_frame_err"}, int'(frame_err_o), 0);
        chk({tag, "_rd_en"},     int'(rd_en_o),     0);
        chk({tag, "_wr_en"},     int'(wr_en_o),     0);
    endtask

    int exp_br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int base, stall, first_v, ones, min_ready;

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_reset_state("reset");

        // 1: single frame, natural writes, bit-reversed reads
        clear_logs();
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_wr_addr", at(wr_log, i), i);
            chk("t1_rd_addr", at(rd_log, i), exp_br[i]);
        end
        chk("t1_outputs", last_log.size(), 8);
        chk("t1_last_7", at(last_log, 7), 1);
        chk("t1_last_6", at(last_log, 6), 0);
        chk("t1_occupancy_end", int'(occupancy_o), 0);

        // 2: both banks fill while the consumer stalls, then drain in order
        clear_logs();
        base = pcnt;
        repeat (24) step(1'b1, 1'b0, 1'b0);
        chk("t2_accepted", pcnt - base, 16);
        chk("t2_in_ready", int'(in_ready_o), 0);
        chk("t2_occupancy", int'(occupancy_o), 2);
        for (int c = 0; c < 80 && (pcnt - base < 24 || occupancy_o != 2'd0 || out_valid_o); c++)
            step(pcnt - base < 24, 1'b1, 1'b0);
        chk("t2_rd_0", at(rd_log, 0), 8);
        chk("t2_rd_1", at(rd_log, 1), 12);
        chk("t2_rd_2", at(rd_log, 2), 10);
        chk("t2_rd_8", at(rd_log, 8), 0);
        chk("t2_reads", rd_log.size(), 24);
        chk("t2_outputs", last_log.size(), 24);

        // 3: three-cycle stall on the 4th output word
        clear_logs();
        repeat (8) step(1'b1, 1'b1, 1'b0);
        stall = 0;
        for (int c = 0; c < 40 && last_log.size() < 8; c++) begin
            if (out_valid_o && last_log.size() == 3 && stall < 3) begin
                stall++;
                in_valid_i = 1'b0; out_ready_i = 1'b0;
                #1;
                chk("t3_stall_rd_en", int'(rd_en_o), 0);
                chk("t3_stall_valid", int'(out_valid_o), 1);
                @(posedge clk);
                #1;
            end else begin
                step(1'b0, 1'b1, 1'b0);
            end
        end
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("t3_stalls", stall, 3);
        for (int i = 0; i < 8; i++) chk("t3_rd_addr", at(rd_log, i), exp_br[i]);
        chk("t3_outputs", last_log.size(), 8);

        // 4: misplaced last flag on the 6th word
        clear_logs();
        chk("t4_err_before", int'(frame_err_o), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, i == 5);
            if (i == 4) chk("t4_err_pre", int'(frame_err_o), 0);
            if (i == 5) chk("t4_err_next", int'(frame_err_o), 1);
        end
        repeat (12) step(1'b0, 1'b1, 1'b0);
        chk("t4_err_sticky", int'(frame_err_o), 1);
        chk("t4_reads", rd_log.size(), 8);
        chk("t4_last_7", at(last_log, 7), 1);

        // 5: reset after the 5th write of the second frame
        repeat (13) step(1'b1, 1'b1, 1'b0);
        rst_i = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        rst_i = 1'b0;
        pcnt = 0;
        chk_reset_state("t5");
        clear_logs();
        step(1'b1, 1'b1, 1'b0);
        chk("t5_first_wr_addr", at(wr_log, 0), 0);
        repeat (7) step(1'b1, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);

        // 6: four back-to-back frames at full rate
        clear_logs();
        base = pcnt;
        min_ready = 1;
        for (int i = 0; i < 32; i++) begin
            if (in_ready_o !== 1'b1) min_ready = 0;
            step(1'b1, 1'b1, 1'b0);
        end
        repeat (14) step(1'b0, 1'b1, 1'b0);
        chk("t6_accepted", pcnt - base, 32);
        chk("t6_in_ready_high", min_ready, 1);
        chk("t6_outputs", last_log.size(), 32);
        first_v = -1;
        for (int i = 0; i < ov_log.size(); i++)
            if (first_v < 0 && ov_log[i] == 1) first_v = i;
        chk("t6_first_valid", first_v, 9);
        ones = 0;
        for (int i = 9; i < 41; i++) ones += at(ov_log, i) == 1 ? 1 : 0;
        chk("t6_valid_run", ones, 32);
        for (int i = 0; i < 8; i++) chk("t6_rd_addr", at(rd_log, i), 8 + exp_br[i]);
        ones = 0;
        foreach (last_log[i]) ones += last_log[i];
        chk("t6_last_count", ones, 4);
        chk("t6_last_31", at(last_log, 31), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
